// File: rtl/prbs_sync_monitor_pkg.sv
// Shared definitions for the PRBS sync monitor and the PRBS transceiver block:
// the acquisition state encoding and the LFSR length of x^25+x^22+1.
package prbs_sync_monitor_pkg;

    // Length of the PRBS LFSR; LOAD must shift in this many received bits.
    localparam int LFSR_LEN = 25;

    // Acquisition states. The encoding is also the STATE_o output value.
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HUNT = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    // Bits needed for a counter that must hold values 0..max_val (at least 1 bit).
    function automatic int cnt_width(input int max_val);
        int w;
        if (max_val < 1) begin
            w = 1;
        end else begin
            w = $clog2(max_val + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/prbs_err_window.sv
// Windowed bit-error counter used while the monitor is locked.
// Counts enabled samples and error strobes; at the end of every C_WIN_LEN-sample
// window it publishes the error count, pulses win_vld and restarts.
// win_end/win_bad are combinational so the parent FSM can act on the same edge.
module prbs_err_window
    import prbs_sync_monitor_pkg::*;
#(
    parameter int C_WIN_LEN = 1024,
    parameter int C_ERR_TH  = 16
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        en,
    input  logic                        clr,
    input  logic                        err,
    output logic                        win_end,
    output logic                        win_bad,
    output logic [$clog2(C_WIN_LEN):0]  err_cnt,
    output logic                        win_vld
);

    localparam int WIN_W = $clog2(C_WIN_LEN);
    localparam int ERR_W = $clog2(C_WIN_LEN) + 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(C_WIN_LEN - 1);

    logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
    logic [ERR_W-1:0] err_acc_reg, err_acc_next;
    logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
    logic             win_vld_reg, win_vld_next;
    logic [ERR_W-1:0] err_sum;

    // Errors of the current window including the sample being presented now.
    assign err_sum = err_acc_reg + ERR_W'(err);

    // The sample being presented completes the window.
    assign win_end = en && (win_cnt_reg == WIN_LAST);

    // The window ending now exceeds the error threshold.
    assign win_bad = (32'(err_sum) > 32'(C_ERR_TH));

    // Window bookkeeping: count samples and errors, publish at window end.
    always_comb begin
        win_cnt_next = win_cnt_reg;
        err_acc_next = err_acc_reg;
        err_cnt_next = err_cnt_reg;
        win_vld_next = 1'b0;
        if (clr) begin
            // Fresh window on lock entry; the last published count is kept.
            win_cnt_next = '0;
            err_acc_next = '0;
        end else if (en) begin
            if (win_cnt_reg == WIN_LAST) begin
                err_cnt_next = err_sum;
                win_vld_next = 1'b1;
                win_cnt_next = '0;
                err_acc_next = '0;
            end else begin
                win_cnt_next = win_cnt_reg + WIN_W'(1);
                err_acc_next = err_sum;
            end
        end
    end

    // Window state registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            win_cnt_reg <= '0;
            err_acc_reg <= '0;
            err_cnt_reg <= '0;
            win_vld_reg <= 1'b0;
        end else begin
            win_cnt_reg <= win_cnt_next;
            err_acc_reg <= err_acc_next;
            err_cnt_reg <= err_cnt_next;
            win_vld_reg <= win_vld_next;
        end
    end

    assign err_cnt = err_cnt_reg;
    assign win_vld = win_vld_reg;

endmodule

// File: rtl/prbs_sync_monitor.sv
// PRBS acquisition sequencer and bit-error monitor.
// LOAD shifts received bits into the RX LFSR, HUNT waits for a clean run of
// matches, LOCK measures windowed errors and drops back to LOAD after too many
// consecutive bad windows. All counting happens only on CK_EE_i samples.
module prbs_sync_monitor
    import prbs_sync_monitor_pkg::*;
#(
    parameter int C_LOAD_LEN = LFSR_LEN,
    parameter int C_SETTLE   = 2,
    parameter int C_RUN_LEN  = 64,
    parameter int C_WIN_LEN  = 1024,
    parameter int C_ERR_TH   = 16,
    parameter int C_BAD_WIN  = 2
) (
    input  logic                        CK_i,
    input  logic                        RST_i,
    input  logic                        CK_EE_i,
    input  logic                        CMP_i,
    input  logic                        RESTART_i,
    output logic                        RX_MODE_o,
    output logic                        LOCK_o,
    output logic [1:0]                  STATE_o,
    output logic                        WIN_VLD_o,
    output logic [$clog2(C_WIN_LEN):0]  ERR_CNT_o,
    output logic [31:0]                 TOTAL_ERR_o,
    output logic                        LOST_o
);

    localparam int LOAD_W   = cnt_width(C_LOAD_LEN - 1);
    localparam int SETTLE_W = cnt_width(C_SETTLE);
    localparam int RUN_W    = cnt_width(C_RUN_LEN - 1);
    localparam int BAD_W    = cnt_width(C_BAD_WIN - 1);

    localparam logic [LOAD_W-1:0]   LOAD_LAST  = LOAD_W'(C_LOAD_LEN - 1);
    localparam logic [RUN_W-1:0]    RUN_LAST   = RUN_W'(C_RUN_LEN - 1);
    localparam logic [BAD_W-1:0]    BAD_LAST   = BAD_W'(C_BAD_WIN - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(C_SETTLE);
    localparam logic [31:0]         TOTAL_MAX  = 32'hFFFF_FFFF;

    state_t              state_reg, state_next;
    logic [LOAD_W-1:0]   load_cnt_reg, load_cnt_next;
    logic [SETTLE_W-1:0] settle_reg, settle_next;
    logic [RUN_W-1:0]    run_reg, run_next;
    logic [BAD_W-1:0]    bad_reg, bad_next;
    logic [31:0]         total_reg, total_next;
    logic                lost_reg, lost_next;

    logic                win_en;
    logic                win_clr;
    logic                err_strobe;
    logic                win_end;
    logic                win_bad;

    // Every enabled sample in LOCK belongs to the current window; a mismatch is an error.
    assign win_en     = CK_EE_i && (state_reg == ST_LOCK);
    assign err_strobe = ~CMP_i;
    // The window restarts from zero on every entry to LOCK.
    assign win_clr    = (state_reg != ST_LOCK) && (state_next == ST_LOCK);

    prbs_err_window #(
        .C_WIN_LEN (C_WIN_LEN),
        .C_ERR_TH  (C_ERR_TH)
    ) u_err_window (
        .clk     (CK_i),
        .srst    (RST_i),
        .en      (win_en),
        .clr     (win_clr),
        .err     (err_strobe),
        .win_end (win_end),
        .win_bad (win_bad),
        .err_cnt (ERR_CNT_o),
        .win_vld (WIN_VLD_o)
    );

    // Next-state logic: acquisition sequencing, settle blanking and bad-window tracking.
    always_comb begin
        state_next    = state_reg;
        load_cnt_next = load_cnt_reg;
        run_next      = run_reg;
        bad_next      = bad_reg;
        lost_next     = 1'b0;
        // Settle drains on enabled samples regardless of state; it only gates CMP use.
        settle_next   = settle_reg;
        if (CK_EE_i && (settle_reg != '0)) begin
            settle_next = settle_reg - SETTLE_W'(1);
        end

        case (state_reg)
            ST_LOAD: begin
                // Received bits are being shifted into the LFSR; CMP is meaningless here.
                if (CK_EE_i) begin
                    if (load_cnt_reg == LOAD_LAST) begin
                        state_next    = ST_HUNT;
                        load_cnt_next = '0;
                    end else begin
                        load_cnt_next = load_cnt_reg + LOAD_W'(1);
                    end
                end
            end
            ST_HUNT: begin
                // Samples still inside the pipeline after the mode change are skipped.
                if (CK_EE_i && (settle_reg == '0)) begin
                    if (!CMP_i) begin
                        state_next = ST_LOAD;
                        run_next   = '0;
                    end else if (run_reg == RUN_LAST) begin
                        state_next = ST_LOCK;
                        run_next   = '0;
                        bad_next   = '0;
                    end else begin
                        run_next = run_reg + RUN_W'(1);
                    end
                end
            end
            ST_LOCK: begin
                if (win_end) begin
                    if (win_bad) begin
                        if (bad_reg == BAD_LAST) begin
                            state_next = ST_LOAD;
                            lost_next  = 1'b1;
                            bad_next   = '0;
                        end else begin
                            bad_next = bad_reg + BAD_W'(1);
                        end
                    end else begin
                        bad_next = '0;
                    end
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase

        // Re-acquire overrides any other decision and is not reported as a loss.
        if (RESTART_i) begin
            state_next    = ST_LOAD;
            lost_next     = 1'b0;
            load_cnt_next = '0;
            run_next      = '0;
            bad_next      = '0;
        end

        // RX_MODE_o follows LOAD membership; blank CMP whenever it toggles.
        if ((state_reg == ST_LOAD) != (state_next == ST_LOAD)) begin
            settle_next = SETTLE_VAL;
        end
    end

    // Cumulative error total: every LOCK mismatch, saturating at all-ones.
    always_comb begin
        total_next = total_reg;
        if (win_en && !CMP_i && (total_reg != TOTAL_MAX)) begin
            total_next = total_reg + 32'd1;
        end
    end

    // State and counter registers.
    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            state_reg    <= ST_LOAD;
            load_cnt_reg <= '0;
            settle_reg   <= '0;
            run_reg      <= '0;
            bad_reg      <= '0;
            total_reg    <= '0;
            lost_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            load_cnt_reg <= load_cnt_next;
            settle_reg   <= settle_next;
            run_reg      <= run_next;
            bad_reg      <= bad_next;
            total_reg    <= total_next;
            lost_reg     <= lost_next;
        end
    end

    assign RX_MODE_o   = (state_reg == ST_LOAD);
    assign LOCK_o      = (state_reg == ST_LOCK);
    assign STATE_o     = state_reg;
    assign TOTAL_ERR_o = total_reg;
    assign LOST_o      = lost_reg;

endmodule

// File: tb/tb_prbs_sync_monitor.sv
// Self-checking bench for prbs_sync_monitor. A behavioural model driven from
// the stimulus pushes expected window results and state transitions into
// queues; a monitor pops and compares them when the DUT presents them.
module tb_prbs_sync_monitor;

    localparam int LOAD_LEN = 25;
    localparam int SETTLE   = 2;
    localparam int RUN_LEN  = 64;
    localparam int WIN_LEN  = 1024;
    localparam int ERR_TH   = 16;
    localparam int BAD_WIN  = 2;
    localparam int ERR_W    = $clog2(WIN_LEN) + 1;
    localparam longint TOTAL_MAX = 64'h0000_0000_FFFF_FFFF;

    logic             clk;
    logic             rst;
    logic             ck_ee;
    logic             cmp_b;
    logic             restart;
    logic             rx_mode;
    logic             lock;
    logic [1:0]       state_o;
    logic             win_vld;
    logic [ERR_W-1:0] err_cnt;
    logic [31:0]      total;
    logic             lost;

    prbs_sync_monitor #(
        .C_LOAD_LEN (LOAD_LEN),
        .C_SETTLE   (SETTLE),
        .C_RUN_LEN  (RUN_LEN),
        .C_WIN_LEN  (WIN_LEN),
        .C_ERR_TH   (ERR_TH),
        .C_BAD_WIN  (BAD_WIN)
    ) dut (
        .CK_i        (clk),
        .RST_i       (rst),
        .CK_EE_i     (ck_ee),
        .CMP_i       (cmp_b),
        .RESTART_i   (restart),
        .RX_MODE_o   (rx_mode),
        .LOCK_o      (lock),
        .STATE_o     (state_o),
        .WIN_VLD_o   (win_vld),
        .ERR_CNT_o   (err_cnt),
        .TOTAL_ERR_o (total),
        .LOST_o      (lost)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; int st; bit lost; longint total;} trans_t;
    typedef struct {int cyc; int errs; longint total;} win_t;
    trans_t tq[$];
    win_t   wq[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    // Reference model: 0=LOAD, 1=HUNT, 2=LOCK, with the samples of the current phase kept as lists.
    int     m_state = 0;
    bit     q_phase[$];
    bit     q_win[$];
    bit     q_bad[$];
    longint m_total = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void fail_msg(string name, longint act, longint exp);
        n_checks++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // True when the last BAD_WIN windows were all bad.
    function automatic bit bad_streak();
        if (q_bad.size() < BAD_WIN) return 1'b0;
        for (int k = 0; k < BAD_WIN; k++)
            if (!q_bad[q_bad.size() - 1 - k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_step(bit en, bit cmp, bit rs, int at);
        int nxt;
        bit lst;
        int errs;
        nxt = m_state;
        lst = 1'b0;
        if (en) begin
            case (m_state)
                0: begin
                    q_phase.push_back(cmp);
                    if (q_phase.size() == LOAD_LEN) nxt = 1;
                end
                1: begin
                    q_phase.push_back(cmp);
                    if (q_phase.size() > SETTLE && !cmp) nxt = 0;
                    else if (q_phase.size() == SETTLE + RUN_LEN) nxt = 2;
                end
                default: begin
                    q_win.push_back(cmp);
                    if (!cmp && m_total < TOTAL_MAX) m_total++;
                    if (q_win.size() == WIN_LEN) begin
                        errs = 0;
                        foreach (q_win[k]) if (!q_win[k]) errs++;
                        wq.push_back('{at, errs, m_total});
                        q_bad.push_back(errs > ERR_TH);
                        q_win.delete();
                        if (bad_streak()) begin
                            nxt = 0;
                            lst = 1'b1;
                        end
                    end
                end
            endcase
        end
        if (rs) begin
            nxt = 0;
            lst = 1'b0;
        end
        if (nxt != m_state || rs) q_phase.delete();
        if (nxt == 2 && m_state != 2) begin
            q_win.delete();
            q_bad.delete();
        end
        if (nxt != m_state) tq.push_back('{at, nxt, lst, m_total});
        m_state = nxt;
    endfunction

    function automatic void model_reset(int at);
        if (m_state != 0) tq.push_back('{at, 0, 1'b0, 0});
        m_state = 0;
        m_total = 0;
        q_phase.delete();
        q_win.delete();
        q_bad.delete();
    endfunction

    task automatic drive(bit en, bit cmp, bit rs);
        @(negedge clk);
        rst     = 1'b0;
        ck_ee   = en;
        cmp_b   = cmp;
        restart = rs;
        model_step(en, cmp, rs, cyc + 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        ck_ee   = 1'b0;
        cmp_b   = 1'b1;
        restart = 1'b0;
        model_reset(cyc + 1);
        drive(0, 1, 0);
    endtask

    task automatic reset_checks(string tag);
        chk({tag, "_state"},   state_o, 0);
        chk({tag, "_rx_mode"}, rx_mode, 1);
        chk({tag, "_lock"},    lock,    0);
        chk({tag, "_win_vld"}, win_vld, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_total"},   total,   0);
        chk({tag, "_lost"},    lost,    0);
    endtask

    // Feed error-free samples (one enabled sample every 'duty' cycles) until the model locks.
    task automatic lock_clean(int duty);
        int n = 0;
        while (m_state != 2 && n < 5000) begin
            for (int d = 1; d < duty; d++) drive(0, $urandom_range(0, 1), 0);
            drive(1, 1, 0);
            n++;
        end
        drive(0, 1, 0);
        chk("lock_reached", lock, 1);
    endtask

    // One full window with exactly nerr mismatches at random distinct positions.
    task automatic run_window(int nerr, int duty);
        bit pat[WIN_LEN];
        int k = 0;
        int p;
        foreach (pat[i]) pat[i] = 1'b1;
        while (k < nerr) begin
            p = $urandom_range(0, WIN_LEN - 1);
            if (pat[p]) begin
                pat[p] = 1'b0;
                k++;
            end
        end
        for (int i = 0; i < WIN_LEN; i++) begin
            for (int d = 1; d < duty; d++) drive(0, $urandom_range(0, 1), 0);
            drive(1, pat[i], 0);
        end
    endtask

    // Monitor: compare every DUT window pulse and state change against the queues.
    initial begin
        int     prev_st;
        win_t   w;
        trans_t t;
        prev_st = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_st = int'(state_o);
            end else begin
                while (wq.size() > 0 && wq[0].cyc < cyc) begin
                    fail_msg("win_missed_cycle", cyc, wq[0].cyc);
                    w = wq.pop_front();
                end
                while (tq.size() > 0 && tq[0].cyc < cyc) begin
                    fail_msg("trans_missed_cycle", cyc, tq[0].cyc);
                    t = tq.pop_front();
                end
                if (win_vld) begin
                    if (wq.size() == 0) begin
                        fail_msg("win_unexpected_pending", 0, 1);
                    end else begin
                        w = wq.pop_front();
                        chk("win_cycle", cyc, w.cyc);
                        chk("win_err_cnt", err_cnt, w.errs);
                        chk("win_total", total, w.total);
                        $display("[%0d] window errs=%0d total=%0d", cyc, err_cnt, total);
                    end
                end
                if (int'(state_o) != prev_st || lost) begin
                    if (tq.size() == 0) begin
                        fail_msg("trans_unexpected_state", state_o, prev_st);
                    end else begin
                        t = tq.pop_front();
                        chk("trans_cycle", cyc, t.cyc);
                        chk("trans_state", state_o, t.st);
                        chk("trans_lost", lost, t.lost);
                        chk("trans_lock", lock, t.st == 2);
                        chk("trans_rx_mode", rx_mode, t.st == 0);
                        chk("trans_total", total, t.total);
                        $display("[%0d] state %0d -> %0d lost=%0d total=%0d",
                                 cyc, prev_st, state_o, lost, total);
                    end
                end
                prev_st = int'(state_o);
            end
        end
    end

    int rate_permil;
    bit en_r;
    bit cmp_r;
    bit rs_r;

    initial begin
        rst     = 1'b1;
        ck_ee   = 1'b0;
        cmp_b   = 1'b1;
        restart = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        reset_checks("reset");
        mon_en = 1'b1;

        // Clean loopback: lock after LOAD+SETTLE+RUN samples, zero-error windows.
        lock_clean(1);
        run_window(0, 1);
        run_window(0, 1);

        // Ten errors in one window: counted, lock kept.
        run_window(10, 1);
        drive(0, 1, 0);
        chk("lock_after_10err", lock, 1);

        // Two consecutive bad windows drop lock, then relock.
        run_window(20, 1);
        run_window(20, 1);
        drive(0, 1, 0);
        chk("rx_mode_after_lost", rx_mode, 1);
        lock_clean(1);

        // Bad, good, bad keeps lock.
        run_window(20, 1);
        run_window(3, 1);
        run_window(20, 1);
        drive(0, 1, 0);
        chk("lock_after_bgb", lock, 1);

        // Restart, then a mismatch at HUNT sample 40 returns to LOAD; relock afterwards.
        drive(1, 1, 1);
        for (int n = 0; n < 300 && !(m_state == 1 && q_phase.size() == 39); n++) drive(1, 1, 0);
        drive(1, 0, 0);
        drive(0, 1, 0);
        chk("hunt_err_lock", lock, 0);
        chk("hunt_err_rx_mode", rx_mode, 1);
        lock_clean(1);

        // One-in-three sample enable.
        drive(1, 1, 1);
        lock_clean(3);
        run_window(7, 3);

        // Restart mid-window keeps TOTAL_ERR_o.
        for (int i = 0; i < 100; i++) drive(1, (i % 9) != 0, 0);
        drive(1, 1, 1);
        drive(0, 1, 0);
        chk("restart_total_kept", total, m_total);
        chk("restart_no_lost", lost, 0);

        // Restart coinciding with a window end: window still reported.
        lock_clean(1);
        for (int i = 0; i < WIN_LEN - 1; i++) drive(1, 1, 0);
        drive(1, 0, 1);
        drive(0, 1, 0);
        chk("restart_winend_state", state_o, 0);

        // Reset mid-LOCK.
        lock_clean(1);
        for (int i = 0; i < 50; i++) drive(1, (i % 4) != 0, 0);
        do_reset();
        reset_checks("mid_reset");

        // Randomized traffic with varying error rates, enables and rare restarts.
        for (int i = 0; i < 15000; i++) begin
            if (i % 1500 == 0) begin
                case ($urandom_range(0, 3))
                    0: rate_permil = 0;
                    1: rate_permil = 5;
                    2: rate_permil = 20;
                    default: rate_permil = 500;
                endcase
            end
            if (i == 7000) begin
                do_reset();
                reset_checks("rand_reset");
            end
            en_r  = ($urandom_range(0, 3) != 0);
            cmp_r = !($urandom_range(0, 999) < rate_permil);
            rs_r  = en_r && ($urandom_range(0, 2999) == 0);
            drive(en_r, cmp_r, rs_r);
        end

        repeat (5) drive(0, 1, 0);
        chk("win_queue_drained", wq.size(), 0);
        chk("trans_queue_drained", tq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
